uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer between the processor's output port and the UART transmitter. Accepts bytes at core speed through a one-cycle push strobe and stores them in a circular FIFO. Hands them one at a time to the transmitter through its `data_tx` / `start_transmit` / `tx_ready` handshake. Holds each byte stable for the whole frame, because the transmitter samples `data_tx` bit by bit while sending.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `clk`  in  1  system clock, shared with the UART.
- `reset`  in  1  synchronous, active-low.
- `push`  in  1  one-cycle strobe: write `push_data` into the FIFO.
- `push_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  number of stored bytes, excluding the byte currently in `data_tx`.
- `overflow`  out  1  sticky; set when `push` arrives while `full`.
- `tx_ready`  in  1  from the UART; low while a frame is being sent.
- `data_tx`  out  8  byte presented to the UART.
- `start_transmit`  out  1  request to the UART to send `data_tx`.

## Operation
- **Storage**
  - Circular RAM of 2^DEPTH_LOG2 x 8.
  - Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is a separate register.
- **Push**
  - Accepted when `push`=1 and `full`=0 at the clock edge: write at the write pointer, increment it, `count`+1.
  - `push` while `full`: data dropped, pointers and `count` unchanged, `overflow` set to 1. `overflow` clears only on reset.
- **Pop**
  - Internal only, issued from IDLE as defined below.
  - Copies the head entry into the `data_tx` register, increments the read pointer, `count`-1.
- **Push and pop in the same cycle**
  - Both take effect; `count` unchanged.
  - `full` is evaluated before the pop, so a push while `full` is dropped even if a pop happens in that cycle.
- **State machine** (3 states, reset to IDLE):
  - IDLE: `start_transmit`=0. If `count`>0 and `tx_ready`=1: pop into `data_tx`, set `start_transmit`=1, go to REQ.
  - REQ: `start_transmit`=1. When `tx_ready`=0 (UART has latched the start bit): `start_transmit`=0, go to SEND.
  - SEND: `start_transmit`=0. When `tx_ready`=1 (stop bit done): go to IDLE.
- **data_tx stability**: `data_tx` changes only on a pop in IDLE. It is constant throughout REQ and SEND.
- **Flags**: `full` = (`count` == 2^DEPTH_LOG2); `empty` = (`count` == 0). Both are combinational from `count`.

## Timing
- **Reset values**: `data_tx`=0, `start_transmit`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, both pointers 0, state IDLE.
- **Reset mid-operation**: FIFO contents are discarded and `start_transmit` drops on the next edge. The UART shares `reset`, so no frame remains outstanding.
- **Latency**: a push at edge N into an empty FIFO with IDLE and `tx_ready`=1 gives `start_transmit`=1 after edge N+1.
- **Request hold**: `start_transmit` stays high until `tx_ready` is seen low. This spans at least one UART enable tick (up to one full baud period), as the UART requires.
- **Back-to-back bytes**: SEND→IDLE takes 1 cycle after `tx_ready` rises; the next pop happens on the following edge. The UART idles at least one baud tick between frames (stop bit plus idle tick).
- **Throughput**: one byte per UART frame. Pushes are accepted every cycle while not `full`.
- **Wrap-around**: pointers roll from 2^DEPTH_LOG2-1 to 0 with no stall.

## Test plan
- **Single byte**: push 0x41 into an empty FIFO while the UART is idle -> `start_transmit` high 1 cycle later with `data_tx`=0x41. The UART serialises start bit 0, then 1,0,0,0,0,0,1,0 LSB first, then stop bit 1. `count` returns to 0 and `empty`=1.
- **Fill and overflow**: with `tx_ready` held low, push 0x00..0x10 (17 bytes) -> `full`=1 after 16 pushes and `count`=16. The 17th push sets `overflow`=1 and is dropped. Releasing `tx_ready` then sends 0x00..0x0F in order.
- **Wrap-around**: push 40 sequential bytes in bursts of 10, each burst issued while the previous one drains -> all 40 bytes appear on `tx` in order, none lost or duplicated.
- **Simultaneous push and pop**: push at the same edge an IDLE pop occurs, with `count`=3 -> `count` stays 3 and the popped byte is the oldest.
- **data_tx stability**: during every frame, `data_tx` is constant from the `start_transmit` rise until `tx_ready` returns high, even with pushes arriving mid-frame.
- **Reset mid-frame**: assert `reset` low for 1 cycle during bit 3 of a frame with 5 bytes queued -> next cycle all outputs are at their reset values, `tx`=1, and no further frames start until new pushes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core output port and the UART transmitter.
// data_tx is loaded only when a byte is popped in IDLE and stays fixed for the whole frame.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  tx_ready,
  output logic [7:0]            data_tx,
  output logic                  start_transmit,
  output logic [1:0]            dbg_state
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Handshake: start_transmit is raised with data_tx valid; the UART accepts it by
  // pulling tx_ready low, and signals frame completion by raising tx_ready again.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e                state_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q;
  logic                  start_q;
  logic [7:0]            data_tx_q;
  logic                  push_ok;
  logic                  pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  // full is judged on the pre-pop count, so a push while full is dropped even if a pop happens.
  assign push_ok = push && !full;
  assign pop     = (state_q == IDLE) && !empty && tx_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      data_tx_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            data_tx_q <= mem_q[rd_ptr_q];
            start_q   <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (!tx_ready) begin
            start_q <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) state_q <= IDLE;
        end
        default: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign count          = count_q;
  assign overflow       = overflow_q;
  assign data_tx        = data_tx_q;
  assign start_transmit = start_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes, a behavioural UART handshake model and a
// scoreboard that checks every transmitted byte and its stability across the frame.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int BAUD  = 4;
  localparam int LIMIT = 2000;

  logic       clk;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_ready;
  logic [7:0] data_tx;
  logic       start_transmit;
  logic [1:0] dbg_state;

  logic       hold;
  logic       exp_ovf;
  logic [7:0] exp_q[$];
  int         total;
  int         bad;

  logic       u_busy;
  int         u_bit;
  int         u_cnt;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_data      (push_data),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .tx_ready       (tx_ready),
    .data_tx        (data_tx),
    .start_transmit (start_transmit),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: call at a negedge; returns at the next negedge
  task automatic push_byte(input logic [7:0] b);
    push      = 1'b1;
    push_data = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !u_busy && dbg_state == 2'd0 && !start_transmit) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_tx"}, 32'(data_tx), 32'h0);
    check({tag, "_start"},   32'(start_transmit), 32'h0);
    check({tag, "_count"},   32'(count), 32'h0);
    check({tag, "_empty"},   32'(empty), 32'h1);
    check({tag, "_full"},    32'(full), 32'h0);
    check({tag, "_ovf"},     32'(overflow), 32'h0);
    check({tag, "_state"},   32'(dbg_state), 32'h0);
  endtask

  // UART model: accepts a request by dropping tx_ready, sends 10 bits of BAUD cycles each
  initial begin
    tx_ready = 1'b1;
    u_busy   = 1'b0;
    u_bit    = 0;
    u_cnt    = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        u_busy   = 1'b0;
        u_bit    = 0;
        tx_ready = !hold;
      end else if (u_busy) begin
        if (u_cnt == BAUD - 1) begin
          u_cnt = 0;
          if (u_bit == 9) begin
            u_busy   = 1'b0;
            tx_ready = !hold;
          end else begin
            u_bit++;
          end
        end else begin
          u_cnt++;
        end
      end else if (start_transmit && tx_ready) begin
        u_busy   = 1'b1;
        u_bit    = 0;
        u_cnt    = 0;
        tx_ready = 1'b0;
      end else begin
        tx_ready = !hold;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic       in_frame;
    logic       saw_low;
    logic       prev_start;
    logic [7:0] frame_byte;
    logic [7:0] exp_b;
    in_frame   = 1'b0;
    saw_low    = 1'b0;
    prev_start = 1'b0;
    frame_byte = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        in_frame   = 1'b0;
        saw_low    = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (in_frame) begin
          check("data_tx_stable", 32'(data_tx), 32'(frame_byte));
          if (!tx_ready) saw_low = 1'b1;
          else if (saw_low) in_frame = 1'b0;
        end
        if (start_transmit && !prev_start) begin
          check("queue_nonempty_at_start", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("tx_order", 32'(data_tx), 32'(exp_b));
          end
          frame_byte = data_tx;
          in_frame   = 1'b1;
          saw_low    = 1'b0;
        end
        prev_start = start_transmit;
      end
    end
  end

  // stimulus
  initial begin
    int n;
    logic seen;
    total     = 0;
    bad       = 0;
    hold      = 1'b0;
    exp_ovf   = 1'b0;
    reset     = 1'b0;
    push      = 1'b0;
    push_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // single byte: start_transmit one cycle after the push edge
    push_byte(8'h41);
    check("lat_start_low", 32'(start_transmit), 32'h0);
    check("lat_count1", 32'(count), 32'h1);
    @(negedge clk);
    check("lat_start_high", 32'(start_transmit), 32'h1);
    check("single_data", 32'(data_tx), 32'h41);
    check("single_count0", 32'(count), 32'h0);
    check("single_empty", 32'(empty), 32'h1);
    wait_drain();

    // fill with the UART stalled, then overflow
    hold = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i));
      if (i == 15) begin
        check("fill_full", 32'(full), 32'h1);
        check("fill_count16", 32'(count), 32'd16);
        check("fill_no_ovf_yet", 32'(overflow), 32'(exp_ovf));
      end
    end
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_count16", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'h1);
    repeat (5) @(negedge clk);
    check("stalled_no_start", 32'(start_transmit), 32'h0);
    hold = 1'b0;
    wait_drain();
    check("ovf_sticky", 32'(overflow), 32'h1);
    check("drained_empty", 32'(empty), 32'h1);

    // push and pop on the same edge with three bytes stored
    hold = 1'b1;
    repeat (3) @(negedge clk);
    push_byte(8'hC0);
    push_byte(8'hC1);
    push_byte(8'hC2);
    check("simul_pre_count", 32'(count), 32'd3);
    hold = 1'b0;
    @(negedge clk);
    push_byte(8'hC3);
    check("simul_count", 32'(count), 32'd3);
    check("simul_start", 32'(start_transmit), 32'h1);
    check("simul_oldest", 32'(data_tx), 32'hC0);
    wait_drain();

    // wrap-around: 40 bytes in bursts of 10, each issued while the previous drains
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push_byte(8'(8'h80 + b * 10 + i));
      n = 0;
      while (exp_q.size() > 3 && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      check("burst_drain_in_time", 32'(n < LIMIT), 32'd1);
    end
    wait_drain();
    check("wrap_count0", 32'(count), 32'h0);
    check("wrap_empty", 32'(empty), 32'h1);

    // reset during bit 3 of a frame with five bytes queued
    for (int i = 0; i < 6; i++) push_byte(8'(8'hE0 + i));
    n = 0;
    while (!(u_busy && u_bit == 3) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("bit3_reached", 32'(n < LIMIT), 32'd1);
    check("midframe_count5", 32'(count), 32'd5);
    check("midframe_ovf", 32'(overflow), 32'(exp_ovf));
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_values("midreset");
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (start_transmit) seen = 1'b1;
    end
    check("no_start_after_reset", 32'(seen), 32'h0);
    push_byte(8'h5A);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
